// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: collects N words, bubble-sorts them ascending through one
// shared W-bit unsigned comparator (one compare per clock), then streams them.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input word handshake (ready only while loading)
//   in_data                input word
//   out_valid/out_ready    sorted word handshake (valid only while draining)
//   out_data, out_last     current sorted word, high on the N-th word
//   busy                   high while sorting or draining
//   swap_count             swaps made for the current batch
module cmp_sort_ctrl #(
    parameter int N = 4,
    parameter int W = 4,
    localparam int SCW = $clog2(N * (N - 1) / 2 + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic           busy,
    output logic [SCW-1:0] swap_count
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] LAST_CMP = IW'(N - 2);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SORT,
        S_DRAIN
    } state_e;

    state_e         state_q, state_d;
    // Load index while loading, output index k while draining.
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  pass_q, pass_d;
    logic [IW-1:0]  cmp_q, cmp_d;
    // Any swap so far in the current pass (excluding this cycle's compare).
    logic           swapped_q, swapped_d;
    logic [SCW-1:0] swap_cnt_q, swap_cnt_d;
    logic [W-1:0]   mem_q [N];
    logic [W-1:0]   mem_d [N];

    logic [IW-1:0]  cmp_nx;
    logic [W-1:0]   cmp_a, cmp_b;
    logic           eq, lst, grt;
    logic           end_pass;

    assign cmp_nx = cmp_q + IW'(1);
    assign cmp_a  = mem_q[cmp_q];
    assign cmp_b  = mem_q[cmp_nx];

    // The single shared magnitude comparator.
    assign eq  = (cmp_a == cmp_b);
    assign lst = (cmp_a < cmp_b);
    assign grt = ~(eq | lst);

    assign end_pass = (cmp_q == LAST_CMP - pass_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        cmp_d      = cmp_q;
        swapped_d  = swapped_q;
        swap_cnt_d = swap_cnt_q;
        mem_d      = mem_q;
        unique case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    mem_d[idx_q] = in_data;
                    if (idx_q == '0) begin
                        swap_cnt_d = '0;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d     = '0;
                        pass_d    = '0;
                        cmp_d     = '0;
                        swapped_d = 1'b0;
                        state_d   = S_SORT;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_SORT: begin
                // Only strictly greater swaps, keeping equal values in order.
                if (grt) begin
                    mem_d[cmp_q]  = cmp_b;
                    mem_d[cmp_nx] = cmp_a;
                    swap_cnt_d    = swap_cnt_q + SCW'(1);
                end
                if (end_pass) begin
                    if (!(swapped_q || grt) || pass_q == LAST_CMP) begin
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        pass_d    = pass_q + IW'(1);
                        cmp_d     = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    cmp_d     = cmp_nx;
                    swapped_d = swapped_q | grt;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            idx_q      <= '0;
            pass_q     <= '0;
            cmp_q      <= '0;
            swapped_q  <= 1'b0;
            swap_cnt_q <= '0;
            for (int j = 0; j < N; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            cmp_q      <= cmp_d;
            swapped_q  <= swapped_d;
            swap_cnt_q <= swap_cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign out_valid  = (state_q == S_DRAIN);
    assign busy       = (state_q != S_LOAD);
    assign out_data   = out_valid ? mem_q[idx_q] : '0;
    assign out_last   = out_valid && (idx_q == LAST_IDX);
    assign swap_count = swap_cnt_q;

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb_cmp_sort_ctrl: scoreboard bench for cmp_sort_ctrl with a queue-based
// reference (sorted order, inversion count, pass-count sort duration).
module tb_cmp_sort_ctrl;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int SCW = $clog2(N * (N - 1) / 2 + 1);

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           busy;
    logic [SCW-1:0] swap_count;

    cmp_sort_ctrl #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .swap_count (swap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_data [$];
    int           exp_sw [$];
    int           exp_cyc [$];

    int           pos       = 0;
    int           sort_cyc  = 0;
    bit           held      = 0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;
    bit           bp_req    = 0;
    int           prev_sw   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int inversions(input logic [W-1:0] a [N]);
        int c = 0;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < j; i++)
                if (a[i] > a[j]) c++;
        return c;
    endfunction

    // Passes with swaps = largest number of bigger words ahead of any word;
    // one extra swap-free pass confirms order unless the pass limit is hit.
    function automatic int sort_cycles(input logic [W-1:0] a [N]);
        int l = 0;
        int c;
        int passes;
        int cyc = 0;
        for (int j = 0; j < N; j++) begin
            c = 0;
            for (int i = 0; i < j; i++)
                if (a[i] > a[j]) c++;
            if (c > l) l = c;
        end
        passes = (l + 1 < N - 1) ? l + 1 : N - 1;
        for (int p = 0; p < passes; p++) cyc += N - 1 - p;
        return cyc;
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            pos      = 0;
            sort_cyc = 0;
            held     = 0;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_swap_count", int'(swap_count), 0);
            chk("rst_out_data", int'(out_data), 0);
        end else begin
            if (busy && !out_valid) sort_cyc++;
            if (busy) chk("in_ready_busy", int'(in_ready), 0);
            if (!out_valid) begin
                if (out_data != '0 || out_last)
                    chk("idle_out_zero", int'({out_last, out_data}), 0);
                held = 0;
            end else begin
                if (held) begin
                    chk("hold_data", int'(out_data), int'(prev_data));
                    chk("hold_last", int'(out_last), int'(prev_last));
                end
                if (out_ready) begin
                    if (exp_data.size() == 0) begin
                        chk("unexpected_out", int'(out_data), -1);
                    end else begin
                        chk("out_data", int'(out_data),
                            int'(exp_data.pop_front()));
                        chk("out_last", int'(out_last), int'(pos == N - 1));
                    end
                    pos++;
                    if (pos == N) begin
                        if (exp_sw.size() > 0)
                            chk("swap_count", int'(swap_count),
                                exp_sw.pop_front());
                        if (exp_cyc.size() > 0)
                            chk("sort_cycles", sort_cyc, exp_cyc.pop_front());
                        pos      = 0;
                        sort_cyc = 0;
                    end
                end
                held      = !out_ready;
                prev_data = out_data;
                prev_last = out_last;
            end
        end
    end

    // Consumer: mostly ready, with one forced 5-cycle stall at k=1.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_req && out_valid && pos == 1) begin
                bp_req    = 0;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
            end
            out_ready = ($urandom_range(3) != 0);
        end
    end

    task automatic load_batch(input logic [W-1:0] a [N]);
        logic [W-1:0] q [$];
        chk("swap_count_held", int'(swap_count), prev_sw);
        for (int j = 0; j < N; j++) q.push_back(a[j]);
        q.sort();
        for (int j = 0; j < N; j++) exp_data.push_back(q[j]);
        prev_sw = inversions(a);
        exp_sw.push_back(prev_sw);
        exp_cyc.push_back(sort_cycles(a));
        for (int j = 0; j < N; j++) begin
            while ($urandom_range(3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = a[j];
            @(negedge clk);
        end
    endtask

    // Junk on the input while busy must never be taken.
    task automatic wait_idle();
        int t = 0;
        in_valid = 1'b1;
        in_data  = W'($urandom);
        while (busy && t < 200) begin
            @(negedge clk);
            in_data = W'($urandom);
            t++;
        end
        in_valid = 1'b0;
        if (t >= 200) chk("busy_timeout", t, 0);
    endtask

    task automatic run_batch(input logic [W-1:0] a [N]);
        load_batch(a);
        wait_idle();
    endtask

    initial begin
        logic [W-1:0] a [N];
        int mx;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        bp_req = 1;
        a = '{4'd9, 4'd6, 4'd3, 4'd0};
        run_batch(a);
        a = '{4'd6, 4'd5, 4'd9, 4'd3};
        run_batch(a);
        a = '{4'd1, 4'd4, 4'd8, 4'd11};
        run_batch(a);
        a = '{4'd0, 4'd0, 4'd0, 4'd0};
        run_batch(a);

        for (int b = 0; b < 30; b++) begin
            mx = ($urandom_range(1) == 0) ? 3 : 15;
            for (int j = 0; j < N; j++) a[j] = W'($urandom_range(mx));
            if (b == 5) bp_req = 1;
            run_batch(a);
        end

        // Reset in the second sort cycle of a reversed batch.
        a = '{4'd15, 4'd10, 4'd5, 4'd0};
        load_batch(a);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_in_ready", int'(in_ready), 1);
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_swap_count", int'(swap_count), 0);
        exp_data.delete();
        exp_sw.delete();
        exp_cyc.delete();
        prev_sw = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        a = '{4'd2, 4'd1, 4'd0, 4'd15};
        run_batch(a);

        chk("scoreboard_empty", exp_data.size(), 0);
        chk("final_idle", int'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
